ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
PS/2 device-to-host receiver, the receive counterpart of the host transmitter in the mouse/VGA subsystem. It observes ps2c/ps2d and never drives them. It filters the clock, samples data on filtered falling edges and assembles 11-bit frames. Each byte is delivered with a one-cycle done tick plus parity, framing and timeout status, for the mouse packet decoder.

Parameters:
FILTER_LEN, 8, number of consecutive identical ps2c samples required to change the filtered clock level
TIMEOUT_CYCLES, 13'd8191, max clk cycles allowed between filtered falling edges inside a frame before abort

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on posedge clk)
rx_en  input  1  receive enable; hold low while the host transmitter owns the bus
ps2d  input  1  PS/2 data line (raw, asynchronous)
ps2c  input  1  PS/2 clock line (raw, asynchronous)
dout  output  8  last received data byte, held until the next completed frame
rx_done_tick  output  1  one-cycle pulse: frame complete, dout and status valid
parity_err  output  1  registered; 1 if the last frame failed odd parity
frame_err  output  1  registered; 1 if the last frame had start!=0 or stop!=1
rx_timeout_tick  output  1  one-cycle pulse: frame aborted by timeout
rx_idle  output  1  1 when the FSM is in IDLE

Behaviour:
- Sync/filter: ps2c passes through a 2-FF synchronizer, then a FILTER_LEN shift register. Filtered level goes 1 on all-ones and 0 on all-zeros, otherwise it holds. fall_edge = filtered_reg & ~filtered_next. ps2d passes through a 2-FF synchronizer only.
- Reset (rst==0 at posedge): filter regs all ones, filtered clock=1 (no spurious edge), state=IDLE, shift reg=0, bit counter=0, timeout counter=0. Outputs: dout=0, parity_err=0, frame_err=0, rx_done_tick=0, rx_timeout_tick=0, rx_idle=1. Reset mid-frame discards the partial frame with no tick.
- Frame format: start(0), d0..d7 LSB first, odd parity, stop(1). Bits are sampled at the filtered falling edge.
- FSM states IDLE, DPS, LOAD:
  - IDLE: rx_idle=1. If fall_edge & rx_en & ps2d_sync==0: shift in the start bit, n=9, clear the timeout counter, go to DPS. fall_edge with ps2d=1 or rx_en=0 is ignored.
  - DPS: on fall_edge, shift ps2d_sync into b[10] (right shift of the 11-bit reg) and clear the timeout counter. If n==0, go to LOAD; else n=n-1. Without fall_edge the timeout counter increments. If it reaches TIMEOUT_CYCLES, pulse rx_timeout_tick, go to IDLE, and leave dout/status unchanged.
  - LOAD: lasts exactly 1 cycle. rx_done_tick=1. The same edge registers dout=b[8:1], parity_err = ~(^b[9:1]) and frame_err = b[0] | ~b[10]. Then go to IDLE.
- Latency: rx_done_tick is high the cycle after the cycle where the stop-bit fall_edge is detected. dout/status become visible on the cycle after rx_done_tick; the consumer samples them then or later.
- rx_en falling mid-frame does not abort. The frame completes or times out. rx_en only gates the start in IDLE.
- A frame with errors still produces rx_done_tick; the consumer checks the flags.
- The counter width covers TIMEOUT_CYCLES. The counter saturates and does not wrap.

Decomposition:
- Shared package ps2_pkg: state encoding localparams (IDLE/DPS/LOAD), FRAME_BITS=11, default FILTER_LEN and TIMEOUT_CYCLES. The host transmitter reuses FILTER_LEN.
- One natural sub-module, ps2_clk_filter: synchronizer, debounce filter and fall_edge output. It is shareable with the transmitter.

Test Plan:
- Byte 0xFA, parity 1, stop 1, ps2c half-period 64 clk -> exactly one rx_done_tick; dout=0xFA, parity_err=0, frame_err=0.
- Byte 0x00 with wrong parity bit 0 -> rx_done_tick; dout=0x00, parity_err=1, frame_err=0.
- Byte 0x55 with stop bit 0 -> rx_done_tick; dout=0x55, frame_err=1.
- Start bit, 4 data bits, then ps2c held high for TIMEOUT_CYCLES+10 -> one rx_timeout_tick, no rx_done_tick, dout unchanged, FSM back in IDLE. Next valid frame 0xAA received correctly.
- 3-cycle low glitches on ps2c in IDLE, then a frame sent with rx_en=0 -> no fall_edge from the glitches, no tick, rx_idle stays 1.
- rst=0 asserted mid-frame (after 6 bits) -> all outputs at reset values next cycle. Subsequent 0xF4 frame yields dout=0xF4 with clean status.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, frame size and default
// filter/timeout settings reused by the host transmitter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } rx_state_t;

  localparam int unsigned FRAME_BITS          = 11;
  localparam int unsigned DEF_FILTER_LEN      = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 8191;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioner: 2-FF synchronizer, level filter requiring FILTER_LEN
// identical samples, and a single-cycle falling-edge strobe.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  output logic fall_edge
);

  logic [1:0]            sync_reg;
  logic [FILTER_LEN-1:0] filter_reg;
  logic [FILTER_LEN-1:0] filter_next;
  logic                  filtered_reg;
  logic                  filtered_next;

  // Everything resets high so the bus looks idle and no edge is faked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg     <= '1;
      filter_reg   <= '1;
      filtered_reg <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[0], ps2c};
      filter_reg   <= filter_next;
      filtered_reg <= filtered_next;
    end
  end

  always_comb begin
    filter_next   = {sync_reg[1], filter_reg[FILTER_LEN-1:1]};
    filtered_next = filtered_reg;
    if (&filter_next)
      filtered_next = 1'b1;
    else if (~|filter_next)
      filtered_next = 1'b0;
  end

  assign fall_edge = filtered_reg & ~filtered_next;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: assembles 11-bit frames on filtered clock
// falling edges and reports each byte with parity, framing and timeout status.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_timeout_tick,
  output logic       rx_idle
);

  localparam int unsigned  TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES);

  rx_state_t             state_reg, state_next;
  logic [3:0]            n_reg, n_next;
  logic [FRAME_BITS-1:0] b_reg, b_next;
  logic [TW-1:0]         tcnt_reg, tcnt_next;
  logic [1:0]            ps2d_sync_reg;
  logic                  ps2d_sync;
  logic                  fall_edge;
  logic                  load_en;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2c      (ps2c),
    .fall_edge (fall_edge)
  );

  assign ps2d_sync = ps2d_sync_reg[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      ps2d_sync_reg <= 2'b11;
      state_reg     <= IDLE;
      n_reg         <= '0;
      b_reg         <= '0;
      tcnt_reg      <= '0;
      dout          <= '0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      ps2d_sync_reg <= {ps2d_sync_reg[0], ps2d};
      state_reg     <= state_next;
      n_reg         <= n_next;
      b_reg         <= b_next;
      tcnt_reg      <= tcnt_next;
      if (load_en) begin
        dout       <= b_reg[8:1];
        parity_err <= ~(^b_reg[9:1]);
        frame_err  <= b_reg[0] | ~b_reg[10];
      end
    end
  end

  // The timeout counter only advances in DPS and stops at TLIMIT, so it never wraps.
  always_comb begin
    state_next      = state_reg;
    n_next          = n_reg;
    b_next          = b_reg;
    tcnt_next       = tcnt_reg;
    load_en         = 1'b0;
    rx_done_tick    = 1'b0;
    rx_timeout_tick = 1'b0;
    rx_idle         = 1'b0;
    case (state_reg)
      IDLE: begin
        rx_idle = 1'b1;
        if (fall_edge && rx_en && !ps2d_sync) begin
          b_next     = {ps2d_sync, b_reg[FRAME_BITS-1:1]};
          n_next     = 4'd9;
          tcnt_next  = '0;
          state_next = DPS;
        end
      end
      DPS: begin
        if (fall_edge) begin
          b_next    = {ps2d_sync, b_reg[FRAME_BITS-1:1]};
          tcnt_next = '0;
          if (n_reg == 4'd0)
            state_next = LOAD;
          else
            n_next = n_reg - 4'd1;
        end else if (tcnt_reg == TLIMIT) begin
          rx_timeout_tick = 1'b1;
          tcnt_next       = '0;
          state_next      = IDLE;
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end
      LOAD: begin
        rx_done_tick = 1'b1;
        load_en      = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: table of whole frames plus directed
// sequences for timeout, clock glitches, disabled receive and mid-frame reset.
module tb_ps2_rx;

  localparam int HALF    = 64;
  localparam int TIMEOUT = 8191;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_en = 1'b0;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick, parity_err, frame_err, rx_timeout_tick, rx_idle;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int busy_cnt = 0;
  logic       cap_pending = 1'b0;
  logic [7:0] cap_dout;
  logic       cap_perr, cap_ferr;

  vec_t vecs[7];

  ps2_rx dut (
    .clk             (clk),
    .rst             (rst),
    .rx_en           (rx_en),
    .ps2d            (ps2d),
    .ps2c            (ps2c),
    .dout            (dout),
    .rx_done_tick    (rx_done_tick),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .rx_timeout_tick (rx_timeout_tick),
    .rx_idle         (rx_idle)
  );

  always #5 clk = ~clk;

  // Result registers are captured on the cycle after the done tick.
  always @(negedge clk) begin
    if (cap_pending) begin
      cap_dout    = dout;
      cap_perr    = parity_err;
      cap_ferr    = frame_err;
      cap_pending = 1'b0;
    end
    if (rx_done_tick) begin
      done_cnt++;
      cap_pending = 1'b1;
    end
    if (rx_timeout_tick) to_cnt++;
    if (!rx_idle) busy_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    to_cnt   = 0;
    busy_cnt = 0;
    cap_dout = 'x;
    cap_perr = 1'bx;
    cap_ferr = 1'bx;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = frame[i];
      repeat (HALF) @(posedge clk);
      #1 ps2c = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clear_counts();
    send_bits({v.stop, v.par, v.data, 1'b0}, 11);
    repeat (200) @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v);
    checkOutput({v.name, " done_cnt"}, done_cnt, 1);
    checkOutput({v.name, " timeout_cnt"}, to_cnt, 0);
    checkOutput({v.name, " dout_after_tick"}, cap_dout, v.exp_dout);
    checkOutput({v.name, " parity_err"}, cap_perr, v.exp_perr);
    checkOutput({v.name, " frame_err"}, cap_ferr, v.exp_ferr);
    checkOutput({v.name, " dout_held"}, dout, v.exp_dout);
    checkOutput({v.name, " rx_idle"}, rx_idle, 1);
  endtask

  initial begin
    vecs[0] = '{"fa_ok",      8'hFA, 1'b1, 1'b1, 8'hFA, 1'b0, 1'b0};
    vecs[1] = '{"00_badpar",  8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"55_badstop", 8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[3] = '{"80_ok",      8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{"0f_ok",      8'h0F, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{"c3_botherr", 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1};
    vecs[6] = '{"aa_ok",      8'hAA, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0};

    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset dout", dout, 8'h00);
    checkOutput("reset parity_err", parity_err, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset done_tick", rx_done_tick, 0);
    checkOutput("reset timeout_tick", rx_timeout_tick, 0);
    checkOutput("reset rx_idle", rx_idle, 1);
    rst   = 1'b1;
    rx_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      check_vec(vecs[i]);
    end

    // Timeout: start plus four data bits, then the clock stays high.
    clear_counts();
    send_bits({2'b11, 8'h5A, 1'b0}, 5);
    repeat (TIMEOUT + 10) @(posedge clk);
    #1;
    checkOutput("timeout tick_cnt", to_cnt, 1);
    checkOutput("timeout done_cnt", done_cnt, 0);
    checkOutput("timeout dout_unchanged", dout, 8'hC3);
    checkOutput("timeout parity_unchanged", parity_err, 1);
    checkOutput("timeout rx_idle", rx_idle, 1);
    applyStimulus(vecs[6]);
    check_vec(vecs[6]);

    // Short clock glitches with data low must never start a frame.
    clear_counts();
    ps2d = 1'b0;
    for (int g = 0; g < 5; g++) begin
      #1 ps2c = 1'b0;
      repeat (3) @(posedge clk);
      #1 ps2c = 1'b1;
      repeat (20) @(posedge clk);
    end
    ps2d = 1'b1;
    checkOutput("glitch busy_cycles", busy_cnt, 0);
    checkOutput("glitch done_cnt", done_cnt, 0);

    // A complete frame while disabled is ignored.
    rx_en = 1'b0;
    clear_counts();
    send_bits({2'b11, 8'h3C, 1'b0}, 11);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("disabled busy_cycles", busy_cnt, 0);
    checkOutput("disabled done_cnt", done_cnt, 0);
    checkOutput("disabled timeout_cnt", to_cnt, 0);
    checkOutput("disabled dout_held", dout, 8'hAA);
    rx_en = 1'b1;

    // Reset in the middle of a frame.
    clear_counts();
    send_bits({2'b11, 8'h77, 1'b0}, 6);
    checkOutput("midframe busy", rx_idle, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst dout", dout, 8'h00);
    checkOutput("midrst parity_err", parity_err, 0);
    checkOutput("midrst frame_err", frame_err, 0);
    checkOutput("midrst done_tick", rx_done_tick, 0);
    checkOutput("midrst timeout_tick", rx_timeout_tick, 0);
    checkOutput("midrst rx_idle", rx_idle, 1);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrst no_done", done_cnt, 0);
    applyStimulus('{"f4_after_rst", 8'hF4, 1'b0, 1'b1, 8'hF4, 1'b0, 1'b0});
    check_vec('{"f4_after_rst", 8'hF4, 1'b0, 1'b1, 8'hF4, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
